// File: rtl/wi23_defs.sv
// wi23_defs: shared SPART register map, controller state encoding and defaults.
package wi23_defs;
   typedef enum logic [1:0] {
      ADDR_DBUF = 2'd0,
      ADDR_SREG = 2'd1,
      ADDR_DBL  = 2'd2,
      ADDR_DBH  = 2'd3
   } spart_ioaddr_t;
   typedef enum logic [2:0] {INIT_DBL, INIT_DBH, POLL, ARB, RD_RX, WR_TX} spart_ctrl_state_t;
   typedef enum logic {GNT_RX, GNT_TX} grant_t;
   localparam int SREG_TX_MSB = 7;
   localparam int SREG_TX_LSB = 4;
   localparam int SREG_RX_MSB = 3;
   localparam int SREG_RX_LSB = 0;
   localparam logic [15:0] DEF_DIVISOR = 16'd325;
endpackage

// File: rtl/spart_ctrl.sv
// spart_ctrl: programs the SPART baud divisor, then polls SREG and moves bytes
// between the CPU holding registers and the SPART with round-robin RX/TX arbitration.
module spart_ctrl
   import wi23_defs::*;
#(
   parameter logic [15:0] DIVISOR = DEF_DIVISOR
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_wr,
   input  logic [15:0]   cfg_div,
   input  logic          tx_valid,
   input  logic [7:0]    tx_data,
   output logic          tx_ready,
   output logic          rx_valid,
   output logic [7:0]    rx_data,
   input  logic          rx_ready,
   output logic          spart_cs_n,
   output logic          spart_rw_n,
   output spart_ioaddr_t spart_addr,
   output logic [7:0]    spart_wdata,
   input  logic [7:0]    spart_rdata
);
   spart_ctrl_state_t state_q, state_d;
   grant_t last_q, last_d;
   logic [15:0] div_q, div_d;
   logic [7:0] hold_q, hold_d, rx_data_q, rx_data_d, sreg_q, sreg_d;
   logic pend_q, pend_d, hold_v_q, hold_v_d, rx_v_q, rx_v_d;
   logic acc, wr, rx_ok, tx_ok;
   spart_ioaddr_t addr;
   logic [7:0] wdata;
   assign rx_ok = (sreg_q[SREG_RX_MSB:SREG_RX_LSB] != '0) & !rx_v_q;
   assign tx_ok = (sreg_q[SREG_TX_MSB:SREG_TX_LSB] != '0) & hold_v_q;
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      div_d     = cfg_wr ? cfg_div : div_q;
      pend_d    = cfg_wr | (pend_q & state_q != ARB);
      hold_d    = hold_q;
      hold_v_d  = hold_v_q;
      rx_v_d    = rx_v_q & !rx_ready;
      rx_data_d = rx_data_q;
      sreg_d    = sreg_q;
      acc       = 1'b1;
      wr        = 1'b0;
      addr      = ADDR_DBUF;
      wdata     = 8'h00;
      if (tx_valid && !hold_v_q) begin
         hold_d   = tx_data;
         hold_v_d = 1'b1;
      end
      case (state_q)
         INIT_DBL: begin
            wr      = 1'b1;
            addr    = ADDR_DBL;
            wdata   = div_q[7:0];
            state_d = INIT_DBH;
         end
         INIT_DBH: begin
            wr      = 1'b1;
            addr    = ADDR_DBH;
            wdata   = div_q[15:8];
            state_d = POLL;
         end
         POLL: begin
            addr    = ADDR_SREG;
            sreg_d  = spart_rdata;
            state_d = ARB;
         end
         ARB: begin
            acc = 1'b0;
            // a pending reprogram outranks data movement; ties go to the side not served last
            if (pend_q) state_d = INIT_DBL;
            else if (rx_ok && (!tx_ok || last_q == GNT_TX)) begin
               state_d = RD_RX;
               last_d  = GNT_RX;
            end else if (tx_ok) begin
               state_d = WR_TX;
               last_d  = GNT_TX;
            end else state_d = POLL;
         end
         RD_RX: begin
            rx_data_d = spart_rdata;
            rx_v_d    = 1'b1;
            state_d   = POLL;
         end
         WR_TX: begin
            wr       = 1'b1;
            wdata    = hold_q;
            hold_v_d = 1'b0;
            state_d  = POLL;
         end
         default: state_d = INIT_DBL;
      endcase
   end
   // bus gated by rst_n so an access in flight drops the instant reset asserts
   assign spart_cs_n  = !(acc & rst_n);
   assign spart_rw_n  = !(wr & rst_n);
   assign spart_addr  = rst_n ? addr : ADDR_DBUF;
   assign spart_wdata = rst_n ? wdata : 8'h00;
   assign tx_ready    = !hold_v_q;
   assign rx_valid    = rx_v_q;
   assign rx_data     = rx_data_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= INIT_DBL;
         last_q    <= GNT_TX;
         div_q     <= DIVISOR;
         pend_q    <= 1'b0;
         hold_q    <= 8'h00;
         hold_v_q  <= 1'b0;
         rx_v_q    <= 1'b0;
         rx_data_q <= 8'h00;
         sreg_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         div_q     <= div_d;
         pend_q    <= pend_d;
         hold_q    <= hold_d;
         hold_v_q  <= hold_v_d;
         rx_v_q    <= rx_v_d;
         rx_data_q <= rx_data_d;
         sreg_q    <= sreg_d;
      end
endmodule

// File: tb/tb_spart_ctrl.sv
// tb_spart_ctrl: directed checks of init, TX/RX transfers, arbitration, reprogram and reset.
module tb_spart_ctrl;
   import wi23_defs::*;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cfg_wr = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
   logic [15:0] cfg_div = 16'h0;
   logic [7:0] tx_data = 8'h0, sreg_val = 8'h0, dbuf_val = 8'h0;
   logic tx_ready, rx_valid, spart_cs_n, spart_rw_n;
   logic [7:0] rx_data, spart_wdata, spart_rdata;
   spart_ioaddr_t spart_addr;
   int total = 0, bad = 0;

   spart_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .spart_cs_n(spart_cs_n), .spart_rw_n(spart_rw_n), .spart_addr(spart_addr),
      .spart_wdata(spart_wdata), .spart_rdata(spart_rdata)
   );

   always #5 clk = ~clk;

   // SPART read model: SREG or DBUF contents while a read is selected
   assign spart_rdata = (!spart_cs_n && spart_rw_n) ? (spart_addr == ADDR_SREG ? sreg_val : dbuf_val) : 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_acc(input string tag, input spart_ioaddr_t a, input logic r);
      int n = 0;
      while (!(spart_cs_n == 1'b0 && spart_addr == a && spart_rw_n == r) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, n < 50, 1);
   endtask

   initial begin
      int g, n, reads;
      repeat (3) @(negedge clk);
      check("rst_cs_n", spart_cs_n, 1);
      check("rst_rw_n", spart_rw_n, 1);
      check("rst_addr", spart_addr, ADDR_DBUF);
      check("rst_wdata", spart_wdata, 8'h00);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      #1;
      check("init_dbl", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBL), 8'h45});
      @(negedge clk);
      check("init_dbh", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBH), 8'h01});
      @(negedge clk);
      check("init_poll", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b01, 6'(ADDR_SREG), 8'h00});
      // TX byte through holding register
      tx_valid = 1'b1; tx_data = 8'h5A; sreg_val = 8'h40;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_drop", tx_ready, 0);
      check("arb_idle_cs", spart_cs_n, 1);
      check("arb_idle_wdata", spart_wdata, 8'h00);
      wait_acc("tx_wr_seen", ADDR_DBUF, 1'b0);
      check("tx_wdata", spart_wdata, 8'h5A);
      @(negedge clk);
      check("tx_ready_back", tx_ready, 1);
      // RX byte with CPU not ready
      sreg_val = 8'h01; dbuf_val = 8'hC3;
      wait_acc("rx_rd_seen", ADDR_DBUF, 1'b1);
      @(negedge clk);
      check("rx_valid_set", rx_valid, 1);
      check("rx_data_c3", rx_data, 8'hC3);
      reads = 0;
      repeat (20) begin
         @(negedge clk);
         if (!spart_cs_n && spart_addr == ADDR_DBUF && spart_rw_n) reads++;
      end
      check("rx_backpressure_reads", reads, 0);
      check("rx_valid_held", rx_valid, 1);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("rx_valid_clr", rx_valid, 0);
      dbuf_val = 8'h3C;
      wait_acc("rx_rd2_seen", ADDR_DBUF, 1'b1);
      @(negedge clk);
      check("rx_data_3c", rx_data, 8'h3C);
      // reprogram during WR_TX, RX byte left pending
      sreg_val = 8'h40; tx_valid = 1'b1; tx_data = 8'hA7;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_acc("cfg_wr_tx_seen", ADDR_DBUF, 1'b0);
      check("cfg_tx_wdata", spart_wdata, 8'hA7);
      cfg_wr = 1'b1; cfg_div = 16'h00A2; sreg_val = 8'h00;
      @(negedge clk);
      cfg_wr = 1'b0;
      check("cfg_poll", {spart_cs_n, spart_rw_n, 6'(spart_addr)}, {2'b01, 6'(ADDR_SREG)});
      @(negedge clk);
      check("cfg_arb", spart_cs_n, 1);
      @(negedge clk);
      check("cfg_dbl", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBL), 8'hA2});
      @(negedge clk);
      check("cfg_dbh", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBH), 8'h00});
      check("cfg_rx_data_kept", rx_data, 8'h3C);
      check("cfg_rx_valid_kept", rx_valid, 1);
      // both sides eligible: grants alternate starting with RX
      @(negedge clk);
      sreg_val = 8'h11; dbuf_val = 8'h99; rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h6E;
      g = 0; n = 0;
      while (g < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (!spart_cs_n && spart_addr == ADDR_DBUF) begin
            check($sformatf("rr_grant%0d", g), spart_rw_n, (g % 2 == 0));
            if (!spart_rw_n) check($sformatf("rr_wdata%0d", g), spart_wdata, 8'h6E);
            g++;
         end
      end
      tx_valid = 1'b0; rx_ready = 1'b0;
      check("rr_grant_count", g, 4);
      check("rr_rx_data", rx_data, 8'h99);
      // reset in the middle of an RX read
      sreg_val = 8'h01; dbuf_val = 8'h55;
      wait_acc("rst_rd_seen", ADDR_DBUF, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs_n", spart_cs_n, 1);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_rx_data", rx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reinit_dbl", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBL), 8'h45});
      @(negedge clk);
      check("reinit_dbh", {spart_cs_n, spart_rw_n, 6'(spart_addr), spart_wdata}, {2'b00, 6'(ADDR_DBH), 8'h01});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spart_ctrl.md
SPART_CTRL -- requirements
Module: spart_ctrl

Interface
REQ-001 Parameter: DIVISOR, default 16'd325, power-up baud divisor (clk/(16*baud) - 1; 9600 baud at 50 MHz).
REQ-002 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 Port: cfg_wr  in  1  one-cycle pulse; requests divisor reprogram.
REQ-005 Port: cfg_div  in  16  new divisor, sampled when cfg_wr=1.
REQ-006 Port: tx_valid  in  1  CPU offers a TX byte.
REQ-007 Port: tx_data  in  8  TX byte.
REQ-008 Port: tx_ready  out  1  holding register empty; byte taken when tx_valid & tx_ready.
REQ-009 Port: rx_valid  out  1  received byte available.
REQ-010 Port: rx_data  out  8  received byte.
REQ-011 Port: rx_ready  in  1  CPU consumes byte when rx_valid & rx_ready.
REQ-012 Port: spart_cs_n  out  1  SPART chip select, active-low.
REQ-013 Port: spart_rw_n  out  1  1 = read, 0 = write.
REQ-014 Port: spart_addr  out  spart_ioaddr_t  register select (DBUF/SREG/DBL/DBH).
REQ-015 Port: spart_wdata  out  8  write data.
REQ-016 Port: spart_rdata  in  8  read data, valid combinationally while cs_n=0 and rw_n=1.

Function
REQ-017 Every SPART access SHALL last exactly one cycle with spart_cs_n=0; spart_cs_n SHALL be 1 in all other states.
REQ-018 States SHALL be INIT_DBL, INIT_DBH, POLL, ARB, RD_RX, WR_TX.
REQ-019 INIT_DBL SHALL write div_reg[7:0] to DBL, then go to INIT_DBH.
REQ-020 INIT_DBH SHALL write div_reg[15:8] to DBH, then go to POLL.
REQ-021 POLL SHALL read SREG and register the value (sreg_q) at the end of the cycle, then go to ARB.
REQ-022 SREG format SHALL be: [7:4] TX free entries, [3:0] RX entries available.
REQ-023 ARB SHALL perform no access. Next state: INIT_DBL if cfg_pend; otherwise RD_RX/WR_TX per REQ-024/025; otherwise POLL.
REQ-024 rx_ok = (sreg_q[3:0]!=0) & !rx_valid; tx_ok = (sreg_q[7:4]!=0) & tx_hold_v.
REQ-025 If only one of rx_ok/tx_ok is set, ARB SHALL grant it. If both are set, ARB SHALL grant the side not recorded in last_grant (round-robin). last_grant SHALL update on every grant.
REQ-026 RD_RX SHALL read DBUF, load rx_data from spart_rdata, and set rx_valid at the cycle end, then go to POLL.
REQ-027 WR_TX SHALL write tx_hold to DBUF and clear tx_hold_v at the cycle end, then go to POLL.
REQ-028 tx_ready SHALL equal !tx_hold_v. A handshake SHALL load tx_hold and set tx_hold_v; capture latency is 1 cycle.
REQ-029 rx_valid SHALL clear on the rx_valid & rx_ready edge. An RD_RX load and a clear cannot coincide, because rx_ok requires !rx_valid.
REQ-030 cfg_wr SHALL load div_reg and set cfg_pend in any state. cfg_pend SHALL clear on entry to INIT_DBL. A cfg_wr during INIT_* SHALL force one further full init sequence after POLL/ARB.
REQ-031 A reprogram SHALL NOT discard tx_hold or rx_data.
REQ-032 spart_wdata SHALL be 0 when not writing. spart_addr SHALL be ADDR_DBUF when idle.

Reset
REQ-033 On rst_n=0, asynchronously: state=INIT_DBL, div_reg=DIVISOR, cfg_pend=0, tx_hold_v=0 (tx_ready=1), rx_valid=0, rx_data=0, sreg_q=0, last_grant=TX, spart_cs_n=1, spart_rw_n=1, spart_addr=ADDR_DBUF, spart_wdata=0.
REQ-034 Reset asserted mid-access SHALL deassert spart_cs_n immediately. The init sequence SHALL rerun after release.

Structure
REQ-035 The state enum (spart_ctrl_state_t), SREG field positions, and the default divisor constant SHALL live in wi23_defs, alongside spart_ioaddr_t.
REQ-036 No sub-module: single FSM plus holding registers.

Verification
REQ-037 Reset release, DIVISOR=325 -> cycle 1: write DBL=0x45; cycle 2: write DBH=0x01; cycle 3: SREG read.
REQ-038 tx_valid with 0x5A, SREG=0x40 -> tx_ready drops next cycle; WR_TX writes DBUF=0x5A; tx_ready returns.
REQ-039 SREG=0x01, rx_ready=0, spart_rdata=0xC3 -> rx_valid=1, rx_data=0xC3. Subsequent polls with SREG=0x01 perform no DBUF read until rx_ready pulses.
REQ-040 SREG=0x11, TX byte held, rx empty, sustained -> grants alternate RX/TX/RX/TX on successive ARB cycles.
REQ-041 cfg_wr with cfg_div=0x00A2 during WR_TX -> the write completes, then POLL, ARB, DBL=0xA2, DBH=0x00; held rx_data is unchanged.
REQ-042 rst_n low during RD_RX -> spart_cs_n=1 and rx_valid=0 asynchronously; after release the DBL/DBH init sequence repeats.
